sobolrng_core: RTL and testbench

//  Sobol sequence generator stage fed directly by the enabled up-counter in sobolrng.

---
 rtl/sobolrng_core_pkg.sv | 9 +
 rtl/sobolrng_core_if.sv | 19 +
 rtl/sobolrng_core_lsz_detect.sv | 17 +
 rtl/sobolrng_core.sv | 45 ++++
 tb/tb_sobolrng_core.sv | 105 ++++++++++
 5 files changed

// File: rtl/sobolrng_core_pkg.sv
// sobol_pkg: shared width, vector types and default direction vectors for sobolrng_core
package sobol_pkg;
  localparam int SOBOL_BW = 8;
  typedef logic [SOBOL_BW-1:0] sobol_vec_t;
  typedef sobol_vec_t sobol_tab_t [SOBOL_BW];
  function automatic sobol_vec_t default_dirvec(input int k, input int bw = SOBOL_BW);
    return sobol_vec_t'(1) << (bw - 1 - k);
  endfunction
endpackage

// File: rtl/sobolrng_core_if.sv
// sobolrng_core_if: step/sample bus of sobolrng_core; load ports exist only with SOBOL_LOAD_EN
interface sobolrng_core_if #(parameter int BW = sobol_pkg::SOBOL_BW);
  localparam int IDXW = $clog2(BW);
  logic            iEn;
  logic [BW-1:0]   iCnt;
  logic [BW-1:0]   oOut;
  logic            oValid;
  logic [IDXW-1:0] oIdx;
`ifdef SOBOL_LOAD_EN
  logic            iLdEn;
  logic [IDXW-1:0] iLdAddr;
  logic [BW-1:0]   iLdData;
  modport master (output iEn, iCnt, iLdEn, iLdAddr, iLdData, input oOut, oValid, oIdx);
  modport slave  (input iEn, iCnt, iLdEn, iLdAddr, iLdData, output oOut, oValid, oIdx);
`else
  modport master (output iEn, iCnt, input oOut, oValid, oIdx);
  modport slave  (input iEn, iCnt, output oOut, oValid, oIdx);
`endif
endinterface

// File: rtl/sobolrng_core_lsz_detect.sv
// lsz_detect: index of the least-significant zero bit of iCnt, oAllOne when there is none
module lsz_detect #(parameter int BW = 8, localparam int IDXW = $clog2(BW)) (
  input  logic [BW-1:0]   iCnt,
  output logic [IDXW-1:0] oIdx,
  output logic            oAllOne
);
  always_comb begin
    oIdx = '0;
    oAllOne = 1'b1;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!iCnt[i]) begin
        oIdx = IDXW'(i);
        oAllOne = 1'b0;
      end
    end
  end
endmodule

// File: rtl/sobolrng_core.sv
// sobolrng_core: one Sobol sample per enabled step from the upstream counter value
// Define SOBOL_LOAD_EN for a runtime-writable direction-vector table.
module sobolrng_core import sobol_pkg::*; #(parameter int BW = SOBOL_BW) (
  input logic iClk,
  input logic iRst,
  sobolrng_core_if.slave bus
);
  localparam int IDXW = $clog2(BW);
  logic [IDXW-1:0] lsz, idx_q, idx_d;
  logic [BW-1:0] vec, out_q, out_d;
  logic all_one, ld, valid_q, valid_d;
  lsz_detect #(.BW(BW)) u_lsz (.iCnt(bus.iCnt), .oIdx(lsz), .oAllOne(all_one));
`ifdef SOBOL_LOAD_EN
  logic [BW-1:0] tab_q [BW];
  assign ld = bus.iLdEn;
  assign vec = tab_q[lsz];
  always_ff @(posedge iClk) begin
    if (iRst) for (int k = 0; k < BW; k++) tab_q[k] <= BW'(default_dirvec(k, BW));
    else if (bus.iLdEn && 32'(bus.iLdAddr) < BW) tab_q[bus.iLdAddr] <= bus.iLdData;
  end
`else
  assign ld = 1'b0;
  assign vec = BW'(default_dirvec(int'(lsz), BW));
`endif
  // counter wrap restarts the sequence at 0 in lockstep with the counter
  always_comb begin
    valid_d = bus.iEn && !ld;
    out_d = valid_d ? (all_one ? '0 : out_q ^ vec) : out_q;
    idx_d = valid_d ? (all_one ? IDXW'(BW - 1) : lsz) : idx_q;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      out_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
    end
  end
  assign bus.oOut = out_q;
  assign bus.oIdx = idx_q;
  assign bus.oValid = valid_q;
endmodule

// File: tb/tb_sobolrng_core.sv
// tb_sobolrng_core: scoreboard bench for sobolrng_core at BW=4 with a counter model on iCnt
module tb_sobolrng_core;
  localparam int BW = 4;
  typedef struct packed {logic [3:0] o; logic v; logic [1:0] i;} exp_t;
  logic iClk = 1'b0;
  logic iRst = 1'b1;
  always #5 iClk = ~iClk;
  sobolrng_core_if #(.BW(BW)) bus();
  sobolrng_core #(.BW(BW)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));
  exp_t sb[$];
  int total = 0, bad = 0;
  logic [3:0] m_out = '0, m_cnt = '0, last = '0;
  logic [1:0] m_idx = '0;
  logic [3:0] mtab [4] = '{4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] first4 [4] = '{4'h8, 4'hC, 4'h4, 4'h6};
  logic [15:0] seen = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic l = 1'b0,
                     input logic [1:0] a = '0, input logic [3:0] d = '0);
    exp_t x;
    int k;
    iRst = r;
    bus.iEn = e;
    bus.iCnt = m_cnt;
`ifdef SOBOL_LOAD_EN
    bus.iLdEn = l;
    bus.iLdAddr = a;
    bus.iLdData = d;
`endif
    k = -1;
    for (int j = BW - 1; j >= 0; j--) if (!m_cnt[j]) k = j;
    x.v = 1'b0;
    if (r) begin
      m_out = '0; m_idx = '0; m_cnt = '0;
      mtab = '{4'h8, 4'h4, 4'h2, 4'h1};
    end else if (l) begin
      if (int'(a) < BW) mtab[a] = d;
    end else if (e) begin
      if (k < 0) begin m_out = '0; m_idx = 2'(BW - 1); end
      else begin m_out = m_out ^ mtab[k]; m_idx = 2'(k); end
      x.v = 1'b1;
      m_cnt = m_cnt + 4'd1;
    end
    x.o = m_out;
    x.i = m_idx;
    sb.push_back(x);
    @(posedge iClk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty got=0 exp=1");
    end else begin
      x = sb.pop_front();
      chk("oOut", 32'(bus.oOut), 32'(x.o));
      chk("oValid", 32'(bus.oValid), 32'(x.v));
      chk("oIdx", 32'(bus.oIdx), 32'(x.i));
    end
    last = bus.oOut;
  endtask

  initial begin
    bus.iEn = 1'b0;
    bus.iCnt = '0;
`ifdef SOBOL_LOAD_EN
    bus.iLdEn = 1'b0;
    bus.iLdAddr = '0;
    bus.iLdData = '0;
`endif
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1);
      if (i < 4) chk("first4", 32'(last), 32'(first4[i]));
      seen[last] = 1'b1;
    end
    chk("wrap_zero", 32'(last), 32'd0);
    chk("perm16", 32'($countones(seen)), 32'd16);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("pre_rst_nonzero", 32'(last != 4'd0), 32'd1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("restart8", 32'(last), 32'h8);
`ifdef SOBOL_LOAD_EN
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'h3);
    cyc(1'b0, 1'b1);
    chk("loaded_v0", 32'(last), 32'h3);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("reset_restores_v0", 32'(last), 32'h8);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
